// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state type and helper functions.
// Used by des_key_sched and des_pc2.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_LAST
  } des_state_e;

  localparam logic [4:0] DES_CNT_LOAD        = 5'd0;
  localparam logic [4:0] DES_CNT_FINAL_ROUND = 5'd16;
  localparam logic [4:0] DES_CNT_LAST        = 5'd17;

  // Tables use FIPS 1-based numbering, bit 1 being the MSB of the vector.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // SHIFT_TAB[k-1] = S(k)
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] des_pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int unsigned k = 0; k < 56; k++) begin
      cd[55 - k] = key[64 - PC1_TAB[k]];
    end
    return cd;
  endfunction

  function automatic logic [27:0] des_rot28(input logic [27:0] x,
                                            input logic [1:0]  n,
                                            input logic        right);
    logic [27:0] r;
    case (n)
      2'd1:    r = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    r = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2: purely combinational 56-bit C||D to 48-bit round key selection.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int unsigned k = 0; k < 48; k++) begin
      subkey[47 - k] = cd[56 - PC2_TAB[k]];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// DES round-key sequencer and round counter (cnt 0, 1..16, 17) for both directions.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  output logic [4:0]  cnt,
  output logic [47:0] subkey,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  des_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic        dir_q;
  logic        key_ok;
  logic        accept;
  logic        stepping;
  logic [1:0]  amt;
  logic [3:0]  sidx;

`ifdef DES_KEY_PARITY_CHK_EN
  logic key_err_q;

  always_comb begin
    key_ok = 1'b1;
    for (int unsigned b = 0; b < 8; b++) begin
      if (!(^key_in[8*b +: 8])) key_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_err_q <= 1'b0;
    else if (state_q == ST_IDLE && start) key_err_q <= ~key_ok;
  end

  assign key_err = key_err_q;
`else
  assign key_ok  = 1'b1;
  assign key_err = 1'b0;
`endif

  assign accept   = (state_q == ST_IDLE) && start && key_ok;
  assign stepping = (state_q == ST_LOAD) || (state_q == ST_ROUND);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: if (cnt_q == DES_CNT_FINAL_ROUND) state_d = ST_LAST;
      ST_LAST:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Leaving cnt=i loads the C/D for round i+1: encrypt left S(i+1),
  // decrypt right S(17-i); decrypt round 1 reuses C0/D0 unshifted.
  always_comb begin
    sidx = dir_q ? 4'(DES_CNT_FINAL_ROUND - cnt_q) : cnt_q[3:0];
    amt  = '0;
    if (stepping && cnt_q != DES_CNT_FINAL_ROUND &&
        !(dir_q && cnt_q == DES_CNT_LOAD)) begin
      amt = SHIFT_TAB[sidx];
    end
    c_d = des_rot28(c_q, amt, dir_q);
    d_d = des_rot28(d_q, amt, dir_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= DES_CNT_LOAD;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= DES_CNT_LOAD;
        {c_q, d_q} <= des_pc1(key_in);
        dir_q      <= decrypt;
      end else if (stepping) begin
        cnt_q <= cnt_q + 5'd1;
        c_q   <= c_d;
        d_q   <= d_d;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  assign cnt  = cnt_q;
  assign busy = stepping;
  assign done = (state_q == ST_LAST);

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a cumulative-shift key-schedule model.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic [4:0]  cnt;
  logic [47:0] subkey;
  logic        busy;
  logic        done;
  logic        key_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] ref_ks [16];
  logic [47:0] sk_first, sk_last;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  int unsigned tb_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int unsigned tb_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int unsigned tb_shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .decrypt (decrypt),
    .key_in  (key_in),
    .cnt     (cnt),
    .subkey  (subkey),
    .busy    (busy),
    .done    (done),
    .key_err (key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int unsigned m);
    logic [55:0] w;
    w = {x, x};
    return w[55 - m -: 28];
  endfunction

  // Kn straight from C0/D0 rotated by the running total of shifts.
  task automatic build_ref(input logic [63:0] key);
    logic [55:0] cd0, cdn;
    int unsigned tot;
    for (int unsigned k = 1; k <= 56; k++) cd0[56 - k] = key[64 - tb_pc1[k - 1]];
    tot = 0;
    for (int unsigned n = 1; n <= 16; n++) begin
      tot += tb_shifts[n - 1];
      cdn = {rotl(cd0[55:28], tot % 28), rotl(cd0[27:0], tot % 28)};
      for (int unsigned k = 1; k <= 48; k++) ref_ks[n - 1][48 - k] = cdn[56 - tb_pc2[k - 1]];
    end
  endtask

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int unsigned b = 0; b < 8; b++) r[8*b] = ~(^r[8*b + 1 +: 7]);
    return r;
  endfunction

  // Caller is at a negedge; start is raised immediately so back-to-back runs abut.
  task automatic run_op(input logic [63:0] key, input logic dec, input int poke_at,
                        input int abort_at, input bit last_poke);
    build_ref(key);
    start = 1'b1; key_in = key; decrypt = dec;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      start = 1'b0; key_in = ~key; decrypt = ~dec;
      chk("cnt", 64'(cnt), 64'(i));
      chk("busy", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      chk("key_err_run", 64'(key_err), 64'd0);
      if (i >= 1) chk("subkey", 64'(subkey), 64'(dec ? ref_ks[16 - i] : ref_ks[i - 1]));
      if (i == 1) sk_first = subkey;
      if (i == 16) sk_last = subkey;
      if (i == poke_at) begin
        start = 1'b1; key_in = KEY_B; decrypt = ~dec;
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        @(negedge clk);
        chk("rst_hold_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    start = last_poke; key_in = key; decrypt = dec;
    chk("last_cnt", 64'(cnt), 64'd17);
    chk("last_done", 64'(done), 64'd1);
    chk("last_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_cnt", 64'(cnt), 64'd17);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0;
    @(negedge clk);
    chk("reset_cnt", 64'(cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_key_err", 64'(key_err), 64'd0);
    chk("reset_subkey", 64'(subkey), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(KEY_A, 1'b0, -1, -1, 1'b0);
    chk("enc_k1", 64'(sk_first), 64'(K1_A));
    chk("enc_k16", 64'(sk_last), 64'(K16_A));

    run_op(KEY_A, 1'b1, -1, -1, 1'b0);
    chk("dec_k1", 64'(sk_first), 64'(K16_A));
    chk("dec_k16", 64'(sk_last), 64'(K1_A));

    // start while busy at cnt=5 and again during LAST: both ignored
    run_op(KEY_A, 1'b0, 5, -1, 1'b1);
    // back-to-back: accepted in the first IDLE cycle
    run_op(KEY_B, 1'b1, -1, -1, 1'b0);

    run_op(KEY_A, 1'b0, -1, 9, 1'b0);
    chk("post_rst_cnt", 64'(cnt), 64'd0);
    run_op(KEY_A, 1'b0, -1, -1, 1'b0);
    chk("post_rst_k1", 64'(sk_first), 64'(K1_A));

`ifdef DES_KEY_PARITY_CHK_EN
    start = 1'b1; key_in = 64'h133457799BBCDFF0; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("par_key_err", 64'(key_err), 64'd1);
    chk("par_busy", 64'(busy), 64'd0);
    chk("par_cnt", 64'(cnt), 64'd17);
    @(negedge clk);
    chk("par_busy_hold", 64'(busy), 64'd0);
    run_op(KEY_A, 1'b0, -1, -1, 1'b0);
    chk("par_ok_k1", 64'(sk_first), 64'(K1_A));
`endif

    for (int r = 0; r < 6; r++) begin
      run_op(fix_parity({$urandom, $urandom}), 1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
